// File: rtl/executor_mul_seq_if.sv
// Command/response bundle between an issuing stage and the sequential multiplier.
// The master issues multiplies; the slave (executor_mul_seq) returns the result and flags.
interface executor_mul_seq_if;
    logic        start;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_acc;
    logic        accumulate;
    logic        set_flags;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        N;
    logic        Z;
    logic        flags_we;

    modport master (
        output start, flush, op_a, op_b, op_acc, accumulate, set_flags,
        input  busy, done, result, N, Z, flags_we
    );

    modport slave (
        input  start, flush, op_a, op_b, op_acc, accumulate, set_flags,
        output busy, done, result, N, Z, flags_we
    );
endinterface

// File: rtl/executor_mul_seq.sv
// Shift-and-add MUL/MLA sequencer that borrows the shared ALU for one add per multiplier bit.
// Iteration stops early once the remaining multiplier bits are all zero.
module executor_mul_seq (
    input  logic                clk,
    input  logic                rst_n,
    executor_mul_seq_if.slave   mif,
    output logic                alu_en,
    output logic [3:0]          alu_opcode,
    output logic [31:0]         alu_op1,
    output logic [31:0]         alu_op2,
    output logic                alu_c_in,
    input  logic [31:0]         alu_result
);
    localparam logic [3:0] OP_OP1 = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h8;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplr;
    logic [4:0]  cnt;
    logic        s;

    logic in_iter, in_done, last_iter;

    assign in_iter   = (state == ITER);
    assign in_done   = (state == DONE);
    // mplr[31:1]==0 means this cycle consumes the highest remaining multiplier bit
    assign last_iter = (mplr[31:1] == 31'd0) || (cnt == 5'd31);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
            s     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && mif.start && !mif.flush) begin
                mcand <= mif.op_a;
                mplr  <= mif.op_b;
                acc   <= mif.accumulate ? mif.op_acc : 32'd0;
                s     <= mif.set_flags;
                cnt   <= '0;
            end else if (in_iter && !mif.flush) begin
                acc   <= alu_result;
                mcand <= {mcand[30:0], 1'b0};
                mplr  <= {1'b0, mplr[31:1]};
                cnt   <= cnt + 5'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (mif.start) state_nx = ITER;
            ITER:    if (last_iter) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Abort wins over everything, including a same-cycle start
        if (mif.flush) state_nx = IDLE;
    end

    always_comb begin
        alu_en       = in_iter;
        alu_opcode   = (in_iter && mplr[0]) ? OP_ADD : OP_OP1;
        alu_op1      = in_iter ? acc   : 32'd0;
        alu_op2      = in_iter ? mcand : 32'd0;
        alu_c_in     = 1'b0;
        mif.busy     = (state != IDLE);
        mif.done     = in_done;
        mif.result   = in_done ? acc : 32'd0;
        mif.N        = in_done & acc[31];
        mif.Z        = in_done & (acc == 32'd0);
        mif.flags_we = in_done & s;
    end
endmodule

// File: tb/tb_executor_mul_seq.sv
// Scoreboarded bench for executor_mul_seq with a behavioural shared ALU.
module tb_executor_mul_seq;
    logic        clk;
    logic        rst_n;
    logic        alu_en;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic        alu_c_in;
    logic [31:0] alu_result;

    executor_mul_seq_if mif();

    executor_mul_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mif        (mif),
        .alu_en     (alu_en),
        .alu_opcode (alu_opcode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_c_in   (alu_c_in),
        .alu_result (alu_result)
    );

    assign alu_result = (alu_opcode == 4'h8) ? alu_op1 + alu_op2 : alu_op1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        n;
        logic        z;
        logic        fwe;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] tb_mplr;
    logic [31:0] tb_mcand;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int num_iters(input logic [31:0] b);
        int k;
        k = 1;
        for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic accum, input logic sf, input bit hold);
        exp_t        e;
        logic [31:0] r;
        @(negedge clk);
        mif.op_a       = a;
        mif.op_b       = b;
        mif.op_acc     = c;
        mif.accumulate = accum;
        mif.set_flags  = sf;
        mif.start      = 1'b1;
        r     = a * b + (accum ? c : 32'd0);
        e.res = r;
        e.n   = r[31];
        e.z   = (r == 32'd0);
        e.fwe = sf;
        e.lat = num_iters(b) + 1;
        e.t0  = cyc;
        sb.push_back(e);
        tb_mplr  = b;
        tb_mcand = a;
        @(posedge clk);
        #1;
        if (!hold) mif.start = 1'b0;
        // Operands are don't-care once accepted; scramble them
        mif.op_a   = $urandom;
        mif.op_b   = $urandom;
        mif.op_acc = $urandom;
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) got = 1'b1;
        end
        if (!got) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (mif.done) begin
                chk("sb_depth", sb.size(), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("result", mif.result, e.res);
                    chk("N", 32'(mif.N), 32'(e.n));
                    chk("Z", 32'(mif.Z), 32'(e.z));
                    chk("flags_we", 32'(mif.flags_we), 32'(e.fwe));
                    chk("latency", cyc - e.t0, e.lat);
                end
                chk("busy_in_done", 32'(mif.busy), 1);
                chk("alu_en_done", 32'(alu_en), 0);
            end else if (mif.busy) begin
                chk("alu_en_iter", 32'(alu_en), 1);
                chk("alu_opcode_iter", 32'(alu_opcode), tb_mplr[0] ? 32'h8 : 32'h0);
                chk("alu_op2_iter", alu_op2, tb_mcand);
                tb_mplr  = tb_mplr >> 1;
                tb_mcand = tb_mcand << 1;
            end else begin
                chk("alu_en_idle", 32'(alu_en), 0);
                chk("alu_opcode_idle", 32'(alu_opcode), 0);
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        mif.start      = 1'b0;
        mif.flush      = 1'b0;
        mif.op_a       = '0;
        mif.op_b       = '0;
        mif.op_acc     = '0;
        mif.accumulate = 1'b0;
        mif.set_flags  = 1'b0;
        tb_mplr        = '0;
        tb_mcand       = '0;

        #12;
        chk("rst_busy", 32'(mif.busy), 0);
        chk("rst_done", 32'(mif.done), 0);
        chk("rst_flags_we", 32'(mif.flags_we), 0);
        chk("rst_alu_en", 32'(alu_en), 0);
        chk("rst_result", mif.result, 0);
        chk("rst_NZ", {30'd0, mif.N, mif.Z}, 0);
        chk("rst_opcode", 32'(alu_opcode), 0);
        chk("rst_alu_ops", alu_op1 | alu_op2, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0);
        wait_idle();
        issue(32'd7, 32'd0, 32'd100, 1'b1, 1'b0, 1'b0);
        wait_idle();
        issue(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1, 1'b0);
        wait_idle();
        issue(32'h1234_5678, 32'h0000_00F3, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        wait_idle();

        // Flush mid-operation, with a competing start that must lose
        issue(32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        mif.flush = 1'b1;
        mif.start = 1'b1;
        mif.op_a  = 32'd9;
        mif.op_b  = 32'd9;
        @(posedge clk);
        #1;
        mif.flush = 1'b0;
        mif.start = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_busy", 32'(mif.busy), 0);
        chk("flush_done", 32'(mif.done), 0);
        issue(32'd2, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // Start held through busy and DONE is ignored; one done only
        issue(32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1);
        wait_idle();
        mif.start = 1'b0;
        @(negedge clk);
        #1;
        chk("start_in_done_ignored", 32'(mif.busy), 0);
        repeat (6) @(negedge clk);
        chk("no_extra_done", sb.size(), 0);

        // Asynchronous reset during a 32-iteration op
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(mif.busy), 0);
        chk("arst_done", 32'(mif.done), 0);
        chk("arst_flags_we", 32'(mif.flags_we), 0);
        chk("arst_alu_en", 32'(alu_en), 0);
        chk("arst_result", mif.result, 0);
        chk("arst_alu_op1", alu_op1, 0);
        sb.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        issue(32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            issue($urandom, $urandom >> $urandom_range(0, 31), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
